// File: rtl/multi_timer.sv
// multi_timer: a bank of independent up-counting timer channels with a CSR
// interface and one-cycle interrupt pulses.
//
// Each channel counts from 0 up to limit = counter_top << prescaler. When it
// reaches the limit it wraps to 0 and pulses its interrupt bit, so the period
// is limit+1 cycles. In one-shot mode the channel disables itself on that
// match. A channel with counter_top == 0 stays idle even when enabled.
//
// CSR map (addresses relative to CsrBase, ch = 0..NumChannels-1):
//   2*ch     CFG : [PrescalerWidth-1:0] prescaler, next CounterWidth bits counter_top
//   2*ch+1   CTL : bit0 enable, bit1 mode (0 periodic, 1 one-shot)
//   2*NumChannels+ch  COUNT (read-only, only when MULTI_TIMER_COUNT_READBACK_EN
//                     is defined; otherwise unmapped)
// Any write to CFG or CTL restarts that channel's count at 0. A write takes
// priority over a match on the same edge, so no interrupt is produced then.
//
// Ports:
//   clk        core clock, all state changes on the rising edge
//   reset_n    synchronous active-low reset
//   csr_we     CSR write strobe
//   csr_addr   CSR address for reads and writes
//   csr_wdata  CSR write data
//   csr_rdata  combinational read data for csr_addr, 0 when unmapped
//   interrupt  per-channel registered one-cycle interrupt pulse
//
// Optional feature macro: MULTI_TIMER_COUNT_READBACK_EN (count readback).

module multi_timer #(
    parameter int          NumChannels    = 4,
    parameter int          CounterWidth   = 16,
    parameter int          PrescalerWidth = 4,
    parameter logic [11:0] CsrBase        = 12'h400
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   csr_we,
    input  logic [11:0]            csr_addr,
    input  logic [31:0]            csr_wdata,
    output logic [31:0]            csr_rdata,
    output logic [NumChannels-1:0] interrupt
);

    // Count width is sized so the largest possible limit never wraps.
    localparam int CntW = CounterWidth + 2**PrescalerWidth;
    localparam int CfgW = PrescalerWidth + CounterWidth;

    logic [PrescalerWidth-1:0] prescaler   [NumChannels];
    logic [CounterWidth-1:0]   counter_top [NumChannels];
    logic                      enable      [NumChannels];
    logic                      mode        [NumChannels];
    logic [CntW-1:0]           count       [NumChannels];

    logic [CntW-1:0]           limit       [NumChannels];
    logic [NumChannels-1:0]    run;
    logic [NumChannels-1:0]    match;
    logic [NumChannels-1:0]    cfg_wr;
    logic [NumChannels-1:0]    ctl_wr;

    // Only the CFG field bits of the write data are ever stored.
    logic unused_wdata;
    assign unused_wdata = ^csr_wdata[31:CfgW];

    function automatic logic [11:0] cfg_addr(input int ch);
        return CsrBase + 12'(2 * ch);
    endfunction

    function automatic logic [11:0] ctl_addr(input int ch);
        return CsrBase + 12'(2 * ch + 1);
    endfunction

    function automatic logic [31:0] cfg_word(input logic [PrescalerWidth-1:0] pre,
                                             input logic [CounterWidth-1:0]   top);
        logic [CfgW+31:0] w;
        w = {32'b0, top, pre};
        return w[31:0];
    endfunction

`ifdef MULTI_TIMER_COUNT_READBACK_EN
    function automatic logic [11:0] cnt_addr(input int ch);
        return CsrBase + 12'(2 * NumChannels + ch);
    endfunction

    function automatic logic [31:0] cnt_word(input logic [CntW-1:0] cnt);
        logic [CntW+31:0] w;
        w = {32'b0, cnt};
        return w[31:0];
    endfunction
`endif

    // Per-channel decode, limit and match detection.
    always_comb begin
        for (int ch = 0; ch < NumChannels; ch++) begin
            limit[ch]  = {{(CntW-CounterWidth){1'b0}}, counter_top[ch]} << prescaler[ch];
            run[ch]    = enable[ch] && (counter_top[ch] != '0);
            match[ch]  = run[ch] && (count[ch] == limit[ch]);
            cfg_wr[ch] = csr_we && (csr_addr == cfg_addr(ch));
            ctl_wr[ch] = csr_we && (csr_addr == ctl_addr(ch));
        end
    end

    // Register stage: configuration, counters and interrupt pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            interrupt <= '0;
            for (int ch = 0; ch < NumChannels; ch++) begin
                prescaler[ch]   <= '0;
                counter_top[ch] <= '0;
                enable[ch]      <= 1'b0;
                mode[ch]        <= 1'b0;
                count[ch]       <= '0;
            end
        end else begin
            for (int ch = 0; ch < NumChannels; ch++) begin
                interrupt[ch] <= 1'b0;
                // A CSR write on this channel overrides any match on this edge.
                if (cfg_wr[ch]) begin
                    prescaler[ch]   <= csr_wdata[PrescalerWidth-1:0];
                    counter_top[ch] <= csr_wdata[CfgW-1:PrescalerWidth];
                    count[ch]       <= '0;
                end else if (ctl_wr[ch]) begin
                    enable[ch] <= csr_wdata[0];
                    mode[ch]   <= csr_wdata[1];
                    count[ch]  <= '0;
                end else if (match[ch]) begin
                    count[ch]     <= '0;
                    interrupt[ch] <= 1'b1;
                    if (mode[ch]) begin
                        enable[ch] <= 1'b0;
                    end
                end else if (run[ch]) begin
                    count[ch] <= count[ch] + CntW'(1);
                end
            end
        end
    end

    // Combinational read mux.
    always_comb begin
        csr_rdata = '0;
        for (int ch = 0; ch < NumChannels; ch++) begin
            if (csr_addr == cfg_addr(ch)) begin
                csr_rdata = cfg_word(prescaler[ch], counter_top[ch]);
            end
            if (csr_addr == ctl_addr(ch)) begin
                csr_rdata = {30'b0, mode[ch], enable[ch]};
            end
`ifdef MULTI_TIMER_COUNT_READBACK_EN
            if (csr_addr == cnt_addr(ch)) begin
                csr_rdata = cnt_word(count[ch]);
            end
`endif
        end
    end

endmodule
